shift_add_multiplier: RTL and testbench



---
 rtl/rv32m_pkg.sv | 21 ++
 rtl/shift_add_multiplier_twos_magnitude.sv | 19 +
 rtl/shift_add_multiplier.sv | 99 +++++++++
 tb/tb_shift_add_multiplier.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M types and constants for the multiply/divide units
package rv32m_pkg;

   // Multiplier sequencing: load, N shift-add steps, one sign fix-up, hold.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      ADJUST = 2'd2,
      DONE   = 2'd3
   } mult_state_t;

   // Bit positions inside is_signed.
   localparam int SIGN_A_BIT = 1;
   localparam int SIGN_B_BIT = 0;

   // Signedness encodings shared with the M-unit wrapper.
   localparam logic [1:0] SIGNED_SS = 2'b11;
   localparam logic [1:0] SIGNED_SU = 2'b10;
   localparam logic [1:0] SIGNED_UU = 2'b00;

endpackage

// File: rtl/shift_add_multiplier_twos_magnitude.sv
// rtl/shift_add_multiplier_twos_magnitude.sv - W-bit conditional two's-complement negate
module twos_magnitude #(
   parameter int N = 32
) (
   input  logic [N-1:0] in,
   input  logic         neg,
   output logic [N-1:0] out
);

   // Negate when requested; the most negative value maps onto itself,
   // which reads correctly as an unsigned magnitude.
   always_comb begin
      out = in;
      if (neg) begin
         out = (~in) + N'(1);
      end
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - radix-2 sequential NxN multiplier with full 2N-bit product
module shift_add_multiplier
   import rv32m_pkg::*;
#(
   parameter int N = 32
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   input  logic [1:0]     is_signed,
   input  logic           start,
   output logic [2*N-1:0] product,
   output logic           finished
);

   localparam int CW = $clog2(N) + 1;

   mult_state_t    state;
   logic [2*N:0]   acc;
   logic [N-1:0]   a_mag;
   logic           neg_result;
   logic [CW-1:0]  counter;

   logic           a_neg;
   logic           b_neg;
   logic [N-1:0]   a_mag_in;
   logic [N-1:0]   b_mag_in;
   logic [N:0]     addend;
   logic [N:0]     sum;
   logic [2*N:0]   acc_shift;
   logic [2*N-1:0] product_fix;

   assign a_neg = is_signed[SIGN_A_BIT] & multiplicand[N-1];
   assign b_neg = is_signed[SIGN_B_BIT] & multiplier[N-1];

   twos_magnitude #(.N(N)) u_mag_a (
      .in  (multiplicand),
      .neg (a_neg),
      .out (a_mag_in)
   );

   twos_magnitude #(.N(N)) u_mag_b (
      .in  (multiplier),
      .neg (b_neg),
      .out (b_mag_in)
   );

   twos_magnitude #(.N(2*N)) u_fix (
      .in  (acc[2*N-1:0]),
      .neg (neg_result),
      .out (product_fix)
   );

   // One shift-add step: conditional add into the upper half (carry kept), then shift right.
   always_comb begin
      addend    = acc[0] ? {1'b0, a_mag} : '0;
      sum       = acc[2*N:N] + addend;
      acc_shift = {1'b0, sum, acc[N-1:1]};
   end

   // Sequencer: start always wins and reloads; otherwise step through MULT and ADJUST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         acc        <= '0;
         a_mag      <= '0;
         neg_result <= 1'b0;
         counter    <= CW'(N);
         product    <= '0;
         finished   <= 1'b0;
      end else if (start) begin
         state      <= MULT;
         acc        <= {{(N+1){1'b0}}, b_mag_in};
         a_mag      <= a_mag_in;
         neg_result <= a_neg ^ b_neg;
         counter    <= CW'(N);
         finished   <= 1'b0;
      end else begin
         case (state)
            MULT: begin
               acc     <= acc_shift;
               counter <= counter - CW'(1);
               if (counter == CW'(1)) begin
                  state <= ADJUST;
               end
            end
            ADJUST: begin
               product  <= product_fix;
               finished <= 1'b1;
               state    <= DONE;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;
   import rv32m_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [1:0]  is_signed;
   logic        start;
   logic [63:0] product;
   logic        finished;

   shift_add_multiplier #(.N(32)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .is_signed    (is_signed),
      .start        (start),
      .product      (product),
      .finished     (finished)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] p;
      int          load;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                        input bit track, input logic [63:0] p, input string nm);
      exp_t e;
      @(negedge CLK);
      multiplicand = a;
      multiplier   = b;
      is_signed    = s;
      start        = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      if (track) begin
         e.p    = p;
         e.load = cyc;
         e.name = nm;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: on each rising finished, pop the oldest expectation and check value and latency.
   initial begin
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST && finished && !prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_finish: product %h, expected no completion", product);
            end else begin
               e = exp_q.pop_front();
               check(e.name, product, e.p);
               check({e.name, "_latency"}, 64'(cyc - e.load), 64'd33);
            end
         end
         prev = finished;
      end
   end

   logic [31:0] va [10];
   logic [31:0] vb [10];
   logic [1:0]  vs [10];
   logic [63:0] vp [10];
   logic [63:0] held;

   initial begin
      va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vs[0] = SIGNED_UU; vp[0] = 64'hFFFF_FFFE_0000_0001;
      va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vs[1] = SIGNED_SS; vp[1] = 64'h4000_0000_0000_0000;
      va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = SIGNED_SS; vp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vs[3] = SIGNED_SU; vp[3] = 64'hFFFF_FFFF_0000_0001;
      va[4] = 32'd7;         vb[4] = 32'd0;         vs[4] = SIGNED_UU; vp[4] = 64'd0;
      va[5] = 32'd7;         vb[5] = 32'd0;         vs[5] = SIGNED_SS; vp[5] = 64'd0;
      va[6] = 32'd7;         vb[6] = 32'd0;         vs[6] = SIGNED_SU; vp[6] = 64'd0;
      va[7] = 32'd7;         vb[7] = 32'd0;         vs[7] = 2'b01;     vp[7] = 64'd0;
      va[8] = 32'd5;         vb[8] = 32'hFFFF_FFFE; vs[8] = 2'b01;     vp[8] = 64'hFFFF_FFFF_FFFF_FFF6;
      va[9] = 32'd1234;      vb[9] = 32'd5678;      vs[9] = SIGNED_SS; vp[9] = 64'd7006652;

      RST          = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      is_signed    = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_product", product, 64'd0);
      check("reset_finished", {63'd0, finished}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 10; i++) begin
         issue(va[i], vb[i], vs[i], 1'b1, vp[i], $sformatf("vec%0d", i));
         wait_done();
      end

      // Restart ten cycles into an operation: only 6*7 may complete.
      issue(32'd3, 32'd5, SIGNED_UU, 1'b0, 64'd0, "");
      repeat (9) @(posedge CLK);
      issue(32'd6, 32'd7, SIGNED_UU, 1'b1, 64'd42, "restart");
      check("restart_finished_low", {63'd0, finished}, 64'd0);
      wait_done();

      // Result held in DONE while operands wander.
      held = 64'd42;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         multiplicand = $urandom;
         multiplier   = $urandom;
         is_signed    = 2'($urandom_range(0, 3));
         @(posedge CLK);
         #1;
         check("stable_product", product, held);
         check("stable_finished", {63'd0, finished}, 64'd1);
      end

      // Asynchronous reset at iteration 20.
      issue(32'd9, 32'd9, SIGNED_UU, 1'b0, 64'd0, "");
      repeat (20) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check("midreset_product", product, 64'd0);
      check("midreset_finished", {63'd0, finished}, 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      issue(32'd2, 32'hFFFF_FFFD, SIGNED_SS, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "after_reset");
      wait_done();

      // Start coinciding with the adjust edge restarts instead of finishing.
      issue(32'd3, 32'd5, SIGNED_UU, 1'b0, 64'd0, "");
      repeat (32) @(posedge CLK);
      issue(32'd100, 32'd100, SIGNED_UU, 1'b1, 64'd10000, "start_on_adjust");
      check("adjust_edge_finished", {63'd0, finished}, 64'd0);
      check("adjust_edge_product_held", product, 64'hFFFF_FFFF_FFFF_FFFA);
      wait_done();

      repeat (3) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
